// File: rtl/lsu_mem_port.sv
// lsu_mem_port: RV32I load/store unit in front of a word-addressed data_mem.
// Aligned accesses use one memory cycle. Misaligned halfword/word accesses are
// split into byte transfers so every write uses a byte-lane strobe.
module lsu_mem_port #(
   parameter int DEPTH = 128,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [2:0]    req_funct3,
   input  logic [31:0]   req_addr,
   input  logic [31:0]   req_wdata,
   output logic          resp_valid,
   output logic          resp_err,
   output logic [31:0]   resp_rdata,
   output logic [AW-1:0] mem_rd_addr,
   input  logic [31:0]   mem_rd_dout,
   output logic [AW-1:0] mem_wr_addr,
   output logic [31:0]   mem_wr_din,
   output logic          mem_we,
   output logic [2:0]    mem_wr_strb
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_XFER = 2'b01,
      ST_RESP = 2'b10
   } state_t;

   // funct3 encodings that have no RV32I meaning for the given direction
   function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
      if (we) begin
         return f3[2] | (f3[1] & f3[0]);
      end else begin
         return (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
      end
   endfunction

   // Index of the final transfer: 0 for aligned, 1 for split half, 3 for split word
   function automatic logic [1:0] last_idx(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b01:   return off[0] ? 2'd1 : 2'd0;
         2'b10:   return (off != 2'b00) ? 2'd3 : 2'd0;
         default: return 2'd0;
      endcase
   endfunction

   // Sign/zero extension of the right-aligned accumulator
   function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] a);
      case (f3)
         3'b000:  return {{24{a[7]}}, a[7:0]};
         3'b001:  return {{16{a[15]}}, a[15:0]};
         3'b100:  return {24'h00_0000, a[7:0]};
         3'b101:  return {16'h0000, a[15:0]};
         default: return a;
      endcase
   endfunction

   state_t          state_q, state_d;
   logic [1:0]      cnt_q, cnt_d;
   logic            we_q, we_d;
   logic [2:0]      f3_q, f3_d;
   logic [AW+1:0]   addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [31:0]     acc_q, acc_d;
   logic            resp_valid_q, resp_valid_d;
   logic            resp_err_q, resp_err_d;
   logic [31:0]     resp_rdata_q, resp_rdata_d;

   logic            serial_s;
   logic [1:0]      last_s;
   logic [AW+1:0]   ba_s;
   logic [1:0]      lane_s;
   logic [AW-1:0]   word_idx_s;
   logic [31:0]     rd_shift_s;
   logic [7:0]      wd_byte_s;
   logic            unused_addr_s;

   // Upper address bits fall outside the memory and are deliberately dropped
   assign unused_addr_s = ^req_addr[31:AW+2];

   assign req_ready  = (state_q == ST_IDLE) && rst;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;

   // Per-transfer address, lane and data selection
   always_comb begin
      serial_s   = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                   ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
      last_s     = last_idx(f3_q, addr_q[1:0]);
      ba_s       = addr_q + {{AW{1'b0}}, cnt_q};
      if (serial_s) begin
         lane_s     = ba_s[1:0];
         word_idx_s = ba_s[AW+1:2];
      end else begin
         lane_s     = addr_q[1:0];
         word_idx_s = addr_q[AW+1:2];
      end
      rd_shift_s = mem_rd_dout >> {lane_s, 3'b000};
      wd_byte_s  = wdata_q[{cnt_q, 3'b000} +: 8];
   end

   // Memory port drive: active only during XFER, writes gated by reset
   always_comb begin
      mem_rd_addr = {AW{1'b0}};
      mem_wr_addr = {AW{1'b0}};
      mem_wr_din  = 32'h0000_0000;
      mem_we      = 1'b0;
      mem_wr_strb = 3'b000;
      if (state_q == ST_XFER) begin
         mem_rd_addr = word_idx_s;
         if (we_q && rst) begin
            mem_we      = 1'b1;
            mem_wr_addr = word_idx_s;
            if (serial_s) begin
               mem_wr_strb = {1'b1, ba_s[1:0]};
               mem_wr_din  = {24'h00_0000, wd_byte_s};
            end else begin
               mem_wr_din = wdata_q;
               case (f3_q[1:0])
                  2'b00:   mem_wr_strb = {1'b1, addr_q[1:0]};
                  2'b01:   mem_wr_strb = addr_q[1] ? 3'b011 : 3'b001;
                  default: mem_wr_strb = 3'b000;
               endcase
            end
         end else begin
            mem_we = 1'b0;
         end
      end else begin
         mem_we = 1'b0;
      end
   end

   // Next-state logic: request capture, byte counter, accumulator, response
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      we_d         = we_q;
      f3_d         = f3_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      acc_d        = acc_q;
      resp_valid_d = 1'b0;
      resp_err_d   = resp_err_q;
      resp_rdata_d = resp_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               addr_d  = req_addr[AW+1:0];
               wdata_d = req_wdata;
               cnt_d   = 2'd0;
               acc_d   = 32'h0000_0000;
               if (f3_illegal(req_we, req_funct3)) begin
                  state_d      = ST_RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = 32'h0000_0000;
               end else begin
                  state_d = ST_XFER;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_XFER: begin
            if (serial_s) begin
               case (cnt_q)
                  2'd0:    acc_d[7:0]   = rd_shift_s[7:0];
                  2'd1:    acc_d[15:8]  = rd_shift_s[7:0];
                  2'd2:    acc_d[23:16] = rd_shift_s[7:0];
                  default: acc_d[31:24] = rd_shift_s[7:0];
               endcase
            end else begin
               acc_d = rd_shift_s;
            end
            if (cnt_q == last_s) begin
               state_d      = ST_RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b0;
               resp_rdata_d = we_q ? 32'h0000_0000 : extend_load(f3_q, acc_d);
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 2'd0;
         we_q         <= 1'b0;
         f3_q         <= 3'b000;
         addr_q       <= {(AW+2){1'b0}};
         wdata_q      <= 32'h0000_0000;
         acc_q        <= 32'h0000_0000;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'h0000_0000;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         f3_q         <= f3_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         acc_q        <= acc_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: table-driven directed bench for lsu_mem_port with a
// behavioural data_mem and hand-written reset / strobe sequences.
module tb_lsu_mem_port;

   localparam int DEPTH = 128;
   localparam int AW    = 7;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [2:0]    req_funct3;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic          resp_valid;
   logic          resp_err;
   logic [31:0]   resp_rdata;
   logic [AW-1:0] mem_rd_addr;
   logic [31:0]   mem_rd_dout;
   logic [AW-1:0] mem_wr_addr;
   logic [31:0]   mem_wr_din;
   logic          mem_we;
   logic [2:0]    mem_wr_strb;

   int checks   = 0;
   int failures = 0;

   // Behavioural data_mem with a bench-side preload port
   logic [31:0]   mem [0:DEPTH-1];
   logic          tb_wr_en = 1'b0;
   logic [AW-1:0] tb_wr_addr = '0;
   logic [31:0]   tb_wr_data = 32'h0;
   int            wr_cnt = 0;
   int            bad_strb = 0;
   logic [AW-1:0] log_addr [0:15];
   logic [2:0]    log_strb [0:15];
   logic [7:0]    log_din  [0:15];

   assign mem_rd_dout = mem[mem_rd_addr];

   always #5 clk = ~clk;

   lsu_mem_port #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
      .mem_rd_addr(mem_rd_addr), .mem_rd_dout(mem_rd_dout),
      .mem_wr_addr(mem_wr_addr), .mem_wr_din(mem_wr_din),
      .mem_we(mem_we), .mem_wr_strb(mem_wr_strb)
   );

   // Memory write model, write log and illegal-strobe monitor
   always @(posedge clk) begin
      if (tb_wr_en) begin
         mem[tb_wr_addr] <= tb_wr_data;
      end else if (mem_we) begin
         case (mem_wr_strb)
            3'b000: mem[mem_wr_addr] <= mem_wr_din;
            3'b001: mem[mem_wr_addr][15:0] <= mem_wr_din[15:0];
            3'b011: mem[mem_wr_addr][31:16] <= mem_wr_din[15:0];
            3'b100: mem[mem_wr_addr][7:0] <= mem_wr_din[7:0];
            3'b101: mem[mem_wr_addr][15:8] <= mem_wr_din[7:0];
            3'b110: mem[mem_wr_addr][23:16] <= mem_wr_din[7:0];
            3'b111: mem[mem_wr_addr][31:24] <= mem_wr_din[7:0];
            default: bad_strb <= bad_strb + 1;
         endcase
      end
      if (mem_we) begin
         log_addr[wr_cnt % 16] <= mem_wr_addr;
         log_strb[wr_cnt % 16] <= mem_wr_strb;
         log_din[wr_cnt % 16]  <= mem_wr_din[7:0];
         wr_cnt <= wr_cnt + 1;
      end
   end

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          exp_lat;
      int          exp_wr;
      logic        chk_mem;
      int          mem_idx;
      logic [31:0] mem_val;
   } vec_t;

   localparam int NV = 22;
   vec_t vecs [0:NV-1];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
      end
   endtask

   task automatic poke(input int idx, input logic [31:0] val);
      tb_wr_en   = 1'b1;
      tb_wr_addr = idx[AW-1:0];
      tb_wr_data = val;
      @(posedge clk);
      #1;
      tb_wr_en   = 1'b0;
   endtask

   // Issue one request and measure response latency from the acceptance edge
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output logic err,
                         output logic [31:0] rd, output logic rdy_after,
                         output logic vld_after, output logic [31:0] rd_after);
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_we     = ~we;
      req_funct3 = 3'b111;
      req_addr   = 32'hFFFF_FFFF;
      req_wdata  = 32'h5A5A_5A5A;
      lat = -1;
      err = 1'b0;
      rd  = 32'h0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (resp_valid) begin
            lat = k;
            err = resp_err;
            rd  = resp_rdata;
            break;
         end
      end
      @(negedge clk);
      rdy_after = req_ready;
      vld_after = resp_valid;
      rd_after  = resp_rdata;
   endtask

   initial begin
      int          lat;
      logic        err, rdy_a, vld_a;
      logic [31:0] rd, rd_a;
      int          base;

      // we, f3, addr, wdata, err, rdata, latency, writes, chk_mem, idx, value
      vecs[0]  = '{1'b0, 3'b000, 32'h5,         32'h0,         1'b0, 32'hFFFF_FFAA, 2, 0, 1'b0, 0,   32'h0};
      vecs[1]  = '{1'b0, 3'b100, 32'h5,         32'h0,         1'b0, 32'h0000_00AA, 2, 0, 1'b0, 0,   32'h0};
      vecs[2]  = '{1'b0, 3'b101, 32'h6,         32'h0,         1'b0, 32'h0000_8899, 2, 0, 1'b0, 0,   32'h0};
      vecs[3]  = '{1'b0, 3'b001, 32'h6,         32'h0,         1'b0, 32'hFFFF_8899, 2, 0, 1'b0, 0,   32'h0};
      vecs[4]  = '{1'b0, 3'b010, 32'h6,         32'h0,         1'b0, 32'h3344_8899, 5, 0, 1'b0, 0,   32'h0};
      vecs[5]  = '{1'b0, 3'b010, 32'h8000_0004, 32'h0,         1'b0, 32'h8899_AABB, 2, 0, 1'b0, 0,   32'h0};
      vecs[6]  = '{1'b1, 3'b010, 32'h0,         32'hDEAD_BEEF, 1'b0, 32'h0,         2, 1, 1'b1, 0,   32'hDEAD_BEEF};
      vecs[7]  = '{1'b0, 3'b001, 32'h5,         32'h0,         1'b0, 32'hFFFF_99AA, 3, 0, 1'b0, 0,   32'h0};
      vecs[8]  = '{1'b1, 3'b001, 32'h1FF,       32'h1234_CAFE, 1'b0, 32'h0,         3, 2, 1'b1, 127, 32'hFE00_0000};
      vecs[9]  = '{1'b0, 3'b010, 32'h0,         32'h0,         1'b0, 32'hDEAD_BECA, 2, 0, 1'b0, 0,   32'h0};
      vecs[10] = '{1'b0, 3'b101, 32'h1FF,       32'h0,         1'b0, 32'h0000_CAFE, 3, 0, 1'b0, 0,   32'h0};
      vecs[11] = '{1'b0, 3'b010, 32'h1FE,       32'h0,         1'b0, 32'hBECA_FE00, 5, 0, 1'b0, 0,   32'h0};
      vecs[12] = '{1'b0, 3'b011, 32'h4,         32'h0,         1'b1, 32'h0,         1, 0, 1'b0, 0,   32'h0};
      vecs[13] = '{1'b1, 3'b011, 32'h0,         32'hFFFF_FFFF, 1'b1, 32'h0,         1, 0, 1'b1, 0,   32'hDEAD_BECA};
      vecs[14] = '{1'b1, 3'b000, 32'h9,         32'hAABB_CC77, 1'b0, 32'h0,         2, 1, 1'b1, 2,   32'h1122_7744};
      vecs[15] = '{1'b1, 3'b001, 32'hA,         32'h0000_BEEF, 1'b0, 32'h0,         2, 1, 1'b1, 2,   32'hBEEF_7744};
      vecs[16] = '{1'b0, 3'b010, 32'h8,         32'h0,         1'b0, 32'hBEEF_7744, 2, 0, 1'b0, 0,   32'h0};
      vecs[17] = '{1'b0, 3'b110, 32'h8,         32'h0,         1'b1, 32'h0,         1, 0, 1'b0, 0,   32'h0};
      vecs[18] = '{1'b1, 3'b010, 32'h3,         32'h0A0B_0C0D, 1'b0, 32'h0,         5, 4, 1'b1, 1,   32'h880A_0B0C};
      vecs[19] = '{1'b0, 3'b010, 32'h3,         32'h0,         1'b0, 32'h0A0B_0C0D, 5, 0, 1'b0, 0,   32'h0};
      vecs[20] = '{1'b1, 3'b100, 32'h4,         32'hFFFF_FFFF, 1'b1, 32'h0,         1, 0, 1'b1, 1,   32'h880A_0B0C};
      vecs[21] = '{1'b0, 3'b000, 32'h6,         32'h0,         1'b0, 32'h0000_000A, 2, 0, 1'b0, 0,   32'h0};

      rst        = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;

      // Preload memory while the unit is held in reset
      for (int w = 0; w < DEPTH; w++) begin
         poke(w, 32'h0);
      end
      poke(1, 32'h8899_AABB);
      poke(2, 32'h1122_3344);

      @(negedge clk);
      chk("reset_req_ready", {31'h0, req_ready}, 32'h0);
      chk("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("reset_resp_rdata", resp_rdata, 32'h0);
      chk("reset_mem_we", {31'h0, mem_we}, 32'h0);
      rst = 1'b1;
      @(negedge clk);
      chk("post_reset_req_ready", {31'h0, req_ready}, 32'h1);

      // Table-driven vectors
      for (int i = 0; i < NV; i++) begin
         base = wr_cnt;
         do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, err, rd, rdy_a, vld_a, rd_a);
         chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
         chk($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
         chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
         chk($sformatf("v%0d_writes", i), wr_cnt - base, vecs[i].exp_wr);
         chk($sformatf("v%0d_ready_after", i), {31'h0, rdy_a}, 32'h1);
         chk($sformatf("v%0d_pulse_len", i), {31'h0, vld_a}, 32'h0);
         chk($sformatf("v%0d_rdata_held", i), rd_a, vecs[i].exp_rdata);
         if (vecs[i].chk_mem) begin
            chk($sformatf("v%0d_mem", i), mem[vecs[i].mem_idx], vecs[i].mem_val);
         end
      end

      // Wrapping byte-serial halfword store: exact strobe sequence
      base = wr_cnt;
      do_req(1'b1, 3'b001, 32'h1FF, 32'h0000_CAFE, lat, err, rd, rdy_a, vld_a, rd_a);
      chk("sh_wrap_latency", lat, 3);
      chk("sh_wrap_w0_addr", {25'h0, log_addr[base % 16]}, 32'd127);
      chk("sh_wrap_w0_strb", {29'h0, log_strb[base % 16]}, 32'd7);
      chk("sh_wrap_w0_din", {24'h0, log_din[base % 16]}, 32'hFE);
      chk("sh_wrap_w1_addr", {25'h0, log_addr[(base + 1) % 16]}, 32'd0);
      chk("sh_wrap_w1_strb", {29'h0, log_strb[(base + 1) % 16]}, 32'd4);
      chk("sh_wrap_w1_din", {24'h0, log_din[(base + 1) % 16]}, 32'hCA);

      // Reset in the middle of a misaligned word store
      poke(0, 32'h0);
      poke(1, 32'h8899_AABB);
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h1;
      req_wdata  = 32'h1122_3344;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_mem_we_in_reset", {31'h0, mem_we}, 32'h0);
      chk("abort_ready_in_reset", {31'h0, req_ready}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("abort_ready_after", {31'h0, req_ready}, 32'h1);
      chk("abort_rdata_cleared", resp_rdata, 32'h0);
      begin
         int seen;
         seen = 0;
         for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (resp_valid) seen++;
         end
         chk("abort_no_resp", seen, 0);
      end
      chk("abort_word0", mem[0], 32'h0000_4400);
      chk("abort_word1", mem[1], 32'h8899_AABB);

      do_req(1'b0, 3'b010, 32'h4, 32'h0, lat, err, rd, rdy_a, vld_a, rd_a);
      chk("after_abort_lw_latency", lat, 2);
      chk("after_abort_lw_rdata", rd, 32'h8899_AABB);

      chk("never_strb_010", bad_strb, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
